// File: rtl/bfloat_mul_pipe.sv
// Three-stage bfloat16 multiplier with valid/ready output handshake.
// Carries a 1-bit add/sub control alongside each product for the downstream adder.
module bfloat_mul_pipe (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        op_in,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [15:0] p,
   output logic        op_out,
   output logic        out_valid,
   input  logic        out_ready
);

   logic        w_en;
   logic        w_a_nan, w_a_inf, w_a_zero;
   logic        w_b_nan, w_b_inf, w_b_zero;
   logic        w_sign;
   logic        w_special;
   logic [15:0] w_spec_res;

   logic        r_s1_valid, r_s1_op, r_s1_special, r_s1_sign;
   logic [15:0] r_s1_spec;
   logic [7:0]  r_s1_ea, r_s1_eb;
   logic [6:0]  r_s1_ma, r_s1_mb;

   logic        r_s2_valid, r_s2_op, r_s2_special, r_s2_sign;
   logic [15:0] r_s2_spec;
   logic [15:0] r_s2_prod;
   logic signed [9:0] r_s2_exp;

   logic        r_s3_valid, r_s3_op;
   logic [15:0] r_p;

   logic [15:0] w_prod;
   logic signed [9:0] w_exp_sum;

   logic [6:0]  w_mant;
   logic        w_lsb, w_rnd, w_sticky, w_round_up;
   logic [7:0]  w_mant_sum;
   logic signed [9:0] w_exp_norm, w_exp_rnd;
   logic [15:0] w_packed;

   assign w_en     = !r_s3_valid | out_ready;
   assign in_ready = w_en;

   assign w_a_nan  = (&a[14:7]) &  (|a[6:0]);
   assign w_a_inf  = (&a[14:7]) & ~(|a[6:0]);
   assign w_a_zero = (a[14:7] == 8'h00);
   assign w_b_nan  = (&b[14:7]) &  (|b[6:0]);
   assign w_b_inf  = (&b[14:7]) & ~(|b[6:0]);
   assign w_b_zero = (b[14:7] == 8'h00);
   assign w_sign   = a[15] ^ b[15];
   assign w_special = w_a_nan | w_b_nan | w_a_inf | w_b_inf | w_a_zero | w_b_zero;

   // Special-case priority: NaN, then Inf*0, then Inf, then zero.
   always_comb begin
      w_spec_res = {w_sign, 15'h0000};
      if (w_a_nan | w_b_nan)
         w_spec_res = 16'hFFFF;
      else if ((w_a_inf & w_b_zero) | (w_b_inf & w_a_zero))
         w_spec_res = 16'hFFFF;
      else if (w_a_inf | w_b_inf)
         w_spec_res = {w_sign, 8'hFF, 7'h00};
   end

   assign w_prod    = {8'h00, 1'b1, r_s1_ma} * {8'h00, 1'b1, r_s1_mb};
   assign w_exp_sum = $signed({2'b00, r_s1_ea}) + $signed({2'b00, r_s1_eb}) - 10'sd127;

   always_comb begin
      w_mant     = r_s2_prod[13:7];
      w_lsb      = r_s2_prod[7];
      w_rnd      = r_s2_prod[6];
      w_sticky   = |r_s2_prod[5:0];
      w_exp_norm = r_s2_exp;
      if (r_s2_prod[15]) begin
         w_mant     = r_s2_prod[14:8];
         w_lsb      = r_s2_prod[8];
         w_rnd      = r_s2_prod[7];
         w_sticky   = |r_s2_prod[6:0];
         w_exp_norm = r_s2_exp + 10'sd1;
      end
      w_round_up = w_rnd & (w_lsb | w_sticky);
      // Mantissa carry-out means 1.111.. rounded up to 10.000.., bump the exponent.
      w_mant_sum = {1'b0, w_mant} + {7'h00, w_round_up};
      w_exp_rnd  = w_exp_norm + $signed({9'h000, w_mant_sum[7]});
      if (r_s2_special)
         w_packed = r_s2_spec;
      else if (w_exp_rnd >= 10'sd255)
         w_packed = {r_s2_sign, 8'hFF, 7'h00};
      else if (w_exp_rnd <= 10'sd0)
         w_packed = {r_s2_sign, 15'h0000};
      else
         w_packed = {r_s2_sign, w_exp_rnd[7:0], w_mant_sum[6:0]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid   <= 1'b0;
         r_s1_op      <= 1'b0;
         r_s1_special <= 1'b0;
         r_s1_sign    <= 1'b0;
         r_s1_spec    <= 16'h0000;
         r_s1_ea      <= 8'h00;
         r_s1_eb      <= 8'h00;
         r_s1_ma      <= 7'h00;
         r_s1_mb      <= 7'h00;
         r_s2_valid   <= 1'b0;
         r_s2_op      <= 1'b0;
         r_s2_special <= 1'b0;
         r_s2_sign    <= 1'b0;
         r_s2_spec    <= 16'h0000;
         r_s2_prod    <= 16'h0000;
         r_s2_exp     <= 10'sd0;
         r_s3_valid   <= 1'b0;
         r_s3_op      <= 1'b0;
         r_p          <= 16'h0000;
      end else if (w_en) begin
         r_s1_valid   <= in_valid;
         r_s1_op      <= op_in;
         r_s1_special <= w_special;
         r_s1_sign    <= w_sign;
         r_s1_spec    <= w_spec_res;
         r_s1_ea      <= a[14:7];
         r_s1_eb      <= b[14:7];
         r_s1_ma      <= a[6:0];
         r_s1_mb      <= b[6:0];
         r_s2_valid   <= r_s1_valid;
         r_s2_op      <= r_s1_op;
         r_s2_special <= r_s1_special;
         r_s2_sign    <= r_s1_sign;
         r_s2_spec    <= r_s1_spec;
         r_s2_prod    <= w_prod;
         r_s2_exp     <= w_exp_sum;
         r_s3_valid   <= r_s2_valid;
         r_s3_op      <= r_s2_op;
         r_p          <= w_packed;
      end
   end

   assign p         = r_p;
   assign op_out    = r_s3_op;
   assign out_valid = r_s3_valid;

endmodule
